// File: rtl/vga_track_pkg.sv
// Shared types and constants for the VGA sync tracker: tracker state, counter
// width, default timing and a saturating increment helper.
package vga_track_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } track_state_e;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 525;
  localparam int LOCK_FRAMES_DEF = 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a sync input and flags its falling edge (current low, previous high).
// The history register resets high so a sync already low after reset is seen as an edge.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic fall_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b1;
    else         prev_q <= sync_i;
  end

  assign fall_o = prev_q & ~sync_i;

endmodule

// File: rtl/vga_sync_tracker.sv
// Tracks incoming VGA h/v sync, reconstructs pixel coordinates and reports lock.
// Define SYNC_TRACK_STATS_EN to add the frame_cnt / err_cnt statistics outputs.
module vga_sync_tracker
  import vga_track_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk_25,
  input  logic             resetN,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic             en,
  output logic [CNT_W-1:0] pxl_x,
  output logic [CNT_W-1:0] pxl_y,
  output logic             pxl_valid,
  output logic             locked,
  output logic             frame_start,
  output logic             sync_err
`ifdef SYNC_TRACK_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [CNT_W:0] H_LEN  = (CNT_W+1)'(H_TOTAL);
  localparam logic [CNT_W:0] V_LEN  = (CNT_W+1)'(V_TOTAL);
  localparam logic [7:0]     LOCK_N = 8'(LOCK_FRAMES);

  logic h_fall, v_fall;

  sync_edge_det u_h_edge (.clk_i(clk_25), .rst_ni(resetN), .sync_i(h_sync), .fall_o(h_fall));
  sync_edge_det u_v_edge (.clk_i(clk_25), .rst_ni(resetN), .sync_i(v_sync), .fall_o(v_fall));

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] pxl_x_q, pxl_x_d, pxl_y_q, pxl_y_d;
  logic             line_seen_q, line_seen_d;
  logic             pxl_valid_q, frame_start_q, sync_err_q, locked_q, skip_q;
  logic [7:0]       good_q;
  track_state_e     state_q;

  logic [CNT_W:0] line_len, frame_len;
  logic           checking, line_err, frame_err, timeout, any_err;

  // x_cnt counts en cycles in the line, y_cnt counts lines that carried any en.
  always_comb begin
    h_cnt_d     = h_fall ? '0 : sat_inc(h_cnt_q);
    v_cnt_d     = v_fall ? '0 : (h_fall ? sat_inc(v_cnt_q) : v_cnt_q);
    x_cnt_d     = h_fall ? '0 : x_cnt_q;
    y_cnt_d     = v_fall ? '0 : y_cnt_q;
    line_seen_d = (h_fall | v_fall) ? 1'b0 : line_seen_q;
    pxl_x_d     = pxl_x_q;
    pxl_y_d     = pxl_y_q;
    if (en) begin
      pxl_x_d = x_cnt_d;
      x_cnt_d = sat_inc(x_cnt_d);
      if (!line_seen_d) y_cnt_d = sat_inc(y_cnt_d);
      line_seen_d = 1'b1;
      pxl_y_d = y_cnt_d - 1'b1;
    end
  end

  // A coincident h edge is handled first, so it is included in the frame count.
  assign line_len  = {1'b0, h_cnt_q} + 1'b1;
  assign frame_len = {1'b0, v_cnt_q} + {{CNT_W{1'b0}}, h_fall};
  assign checking  = (state_q != SEARCH);
  assign line_err  = checking & h_fall & ~skip_q & (line_len != H_LEN);
  assign frame_err = checking & v_fall & (frame_len != V_LEN);
  assign timeout   = checking & ~h_fall & (h_cnt_q == CNT_MAX);
  assign any_err   = line_err | frame_err | timeout;

  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      pxl_x_q       <= '0;
      pxl_y_q       <= '0;
      line_seen_q   <= 1'b0;
      pxl_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      pxl_x_q       <= pxl_x_d;
      pxl_y_q       <= pxl_y_d;
      line_seen_q   <= line_seen_d;
      pxl_valid_q   <= en;
      frame_start_q <= v_fall;
    end
  end

  // skip_q masks the first line after acquisition, which started mid-line.
  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      skip_q     <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (v_fall) begin
            state_q <= MEASURE;
            good_q  <= '0;
            skip_q  <= 1'b1;
          end
        end
        MEASURE, LOCKED: begin
          if (any_err) begin
            state_q    <= SEARCH;
            sync_err_q <= 1'b1;
            locked_q   <= 1'b0;
          end else begin
            if (h_fall) skip_q <= 1'b0;
            if (v_fall && state_q == MEASURE) begin
              good_q <= good_q + 1'b1;
              if (good_q + 1'b1 >= LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign pxl_x       = pxl_x_q;
  assign pxl_y       = pxl_y_q;
  assign pxl_valid   = pxl_valid_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;

`ifdef SYNC_TRACK_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_start_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (sync_err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Directed bench for vga_sync_tracker: lock, line error and relock, pixel
// coordinates, async reset, coincident syncs and h_sync timeout.
module tb_vga_sync_tracker;
  import vga_track_pkg::*;

  // 656 x 12 raster with a 640-wide, 11-line active area
  localparam int H_T      = 656;
  localparam int V_T      = 12;
  localparam int ACT_W    = 640;
  localparam int ACT_H    = 11;
  localparam int HS_START = 644;
  localparam int HS_END   = 652;
  localparam int VS_LINE  = 11;
  localparam int BOUND    = 20000;

  logic        clk_25 = 1'b0;
  logic        resetN = 1'b0;
  logic        hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic [10:0] pxl_x, pxl_y;
  logic        pxl_valid, locked, frame_start, sync_err;

  int n_checks = 0;
  int n_errors = 0;
  int gx = 0, gy = 0, last_x = -1, last_y = -1;
  int err_seen = 0;
  bit coin = 1'b0;

  always #20 clk_25 = ~clk_25;

  vga_sync_tracker #(.H_TOTAL(H_T), .V_TOTAL(V_T), .LOCK_FRAMES(2)) dut (
    .clk_25     (clk_25),
    .resetN     (resetN),
    .h_sync     (hs),
    .v_sync     (vs),
    .en         (de),
    .pxl_x      (pxl_x),
    .pxl_y      (pxl_y),
    .pxl_valid  (pxl_valid),
    .locked     (locked),
    .frame_start(frame_start),
    .sync_err   (sync_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One raster position per clock; outputs are sampled 1 ns after the edge.
  task automatic gen_cycle();
    hs = !(gx >= HS_START && gx < HS_END);
    if (coin) vs = !((gy == VS_LINE && gx >= HS_START) || (gy == 0 && gx < HS_START));
    else      vs = !(gy == VS_LINE);
    de = (gx < ACT_W) && (gy < ACT_H);
    @(posedge clk_25);
    #1;
    last_x = gx;
    last_y = gy;
    if (sync_err) err_seen++;
    gx++;
    if (gx == H_T) begin
      gx = 0;
      gy = (gy + 1) % V_T;
    end
  endtask

  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    do begin
      gen_cycle();
      n++;
    end while (!(last_x == tx && last_y == ty) && n < BOUND);
    if (n >= BOUND) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_to: reached x=%0d y=%0d required x=%0d y=%0d", last_x, last_y, tx, ty);
    end
  endtask

  initial begin
    int first, pulses;

    // reset state
    repeat (3) @(posedge clk_25);
    #1;
    check_val("rst_pxl_x", 32'(pxl_x), 0);
    check_val("rst_pxl_y", 32'(pxl_y), 0);
    check_val("rst_pxl_valid", 32'(pxl_valid), 0);
    check_val("rst_locked", 32'(locked), 0);
    check_val("rst_frame_start", 32'(frame_start), 0);
    check_val("rst_sync_err", 32'(sync_err), 0);
    resetN = 1'b1;

    // acquisition: entry edge plus two good frames
    gx = 0; gy = VS_LINE; err_seen = 0;
    gen_cycle();
    check_val("acq_fs1", 32'(frame_start), 1);
    check_val("acq_lock1", 32'(locked), 0);
    run_to(0, VS_LINE);
    check_val("acq_fs2", 32'(frame_start), 1);
    check_val("acq_lock2", 32'(locked), 0);
    run_to(H_T - 1, VS_LINE - 1);
    check_val("acq_lock_pre3", 32'(locked), 0);
    gen_cycle();
    check_val("acq_lock3", 32'(locked), 1);
    check_val("acq_fs3", 32'(frame_start), 1);
    gen_cycle();
    check_val("acq_fs_pulse_end", 32'(frame_start), 0);
    check_val("acq_no_err", 32'(err_seen), 0);

    // shortened line 9, pixel checks on line 10, then relock
    run_to(H_T - 2, 9);
    gx = 0; gy = 10;
    run_to(0, 10);
    check_val("px_first_x", 32'(pxl_x), 0);
    check_val("px_first_y", 32'(pxl_y), 10);
    check_val("px_first_valid", 32'(pxl_valid), 1);
    check_val("px_first_locked", 32'(locked), 1);
    run_to(ACT_W - 1, 10);
    check_val("px_last_x", 32'(pxl_x), 639);
    check_val("px_last_valid", 32'(pxl_valid), 1);
    gen_cycle();
    check_val("px_blank_valid", 32'(pxl_valid), 0);
    run_to(HS_START - 1, 10);
    check_val("short_pre_err", 32'(sync_err), 0);
    check_val("short_pre_locked", 32'(locked), 1);
    gen_cycle();
    check_val("short_err", 32'(sync_err), 1);
    check_val("short_locked", 32'(locked), 0);
    gen_cycle();
    check_val("short_err_pulse_end", 32'(sync_err), 0);
    err_seen = 0;
    run_to(0, VS_LINE);
    check_val("relock_fs1", 32'(frame_start), 1);
    check_val("relock_lock1", 32'(locked), 0);
    run_to(0, VS_LINE);
    check_val("relock_lock2", 32'(locked), 0);
    run_to(H_T - 1, VS_LINE - 1);
    gen_cycle();
    check_val("relock_lock3", 32'(locked), 1);
    check_val("relock_no_err", 32'(err_seen), 0);

    // asynchronous reset mid-frame, then relock with coincident sync edges
    run_to(100, 3);
    check_val("pre_rst_pxl_x", 32'(pxl_x), 100);
    #5;
    resetN = 1'b0;
    #1;
    check_val("arst_pxl_x", 32'(pxl_x), 0);
    check_val("arst_pxl_y", 32'(pxl_y), 0);
    check_val("arst_valid", 32'(pxl_valid), 0);
    check_val("arst_locked", 32'(locked), 0);
    check_val("arst_h_cnt", 32'(dut.h_cnt_q), 0);
    gen_cycle();
    gen_cycle();
    check_val("arst_hold_locked", 32'(locked), 0);
    check_val("arst_hold_fs", 32'(frame_start), 0);
    resetN = 1'b1;
    coin = 1'b1;
    err_seen = 0;
    run_to(HS_START, VS_LINE);
    check_val("co_fs1", 32'(frame_start), 1);
    check_val("co_lock1", 32'(locked), 0);
    run_to(HS_START, VS_LINE);
    check_val("co_lock2", 32'(locked), 0);
    run_to(HS_START - 1, VS_LINE);
    check_val("co_lock_pre3", 32'(locked), 0);
    gen_cycle();
    check_val("co_err", 32'(sync_err), 0);
    check_val("co_fs3", 32'(frame_start), 1);
    check_val("co_lock3", 32'(locked), 1);
    check_val("co_v_cnt", 32'(dut.v_cnt_q), 0);
    check_val("co_no_err", 32'(err_seen), 0);

    // h_sync stuck high while locked
    hs = 1'b1; vs = 1'b1; de = 1'b0;
    first = 0;
    pulses = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk_25);
      #1;
      if (sync_err) begin
        pulses++;
        if (first == 0) first = n;
      end
      if (n == 2047) check_val("to_locked_2047", 32'(locked), 1);
    end
    check_val("to_first_err", 32'(first), 2048);
    check_val("to_err_pulses", 32'(pulses), 1);
    check_val("to_locked", 32'(locked), 0);
    check_val("to_state", 32'(dut.state_q), 32'(SEARCH));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(40 * 120000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
